// File: rtl/piezo_key_arbiter.sv
// Round-robin arbiter that shares one piezo pin among N debounced keys.
// Each grant plays the key's square-wave tone for NOTE_LEN cycles, then stays silent for GAP_LEN cycles.
module piezo_key_arbiter #(
    parameter int                   N_KEYS   = 8,
    parameter logic [23:0]          NOTE_LEN = 24'd250000,
    parameter logic [23:0]          GAP_LEN  = 24'd50000,
    parameter logic [N_KEYS*16-1:0] HALF_TBL = {16'd956, 16'd1012, 16'd1136, 16'd1276,
                                                16'd1432, 16'd1517, 16'd1703, 16'd1911}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         key_trig,
    input  logic                      stop,
    output logic                      piezo,
    output logic                      busy,
    output logic [$clog2(N_KEYS)-1:0] cur_key,
    output logic                      cur_valid,
    output logic [N_KEYS-1:0]         pending
);

    localparam int KW = $clog2(N_KEYS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [KW-1:0]     rr_q, rr_d;
    logic [KW-1:0]     cur_key_q, cur_key_d;
    logic [23:0]       cnt_q, cnt_d;
    logic [15:0]       half_cnt_q, half_cnt_d;
    logic              piezo_q, piezo_d;
    logic              busy_q, busy_d;
    logic              cur_valid_q, cur_valid_d;

    logic              found;
    logic [KW-1:0]     grant_key;
    logic              take_grant;
    logic [15:0]       half;
    int                idx;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        rr_d        = rr_q;
        cur_key_d   = cur_key_q;
        cnt_d       = cnt_q;
        half_cnt_d  = half_cnt_q;
        piezo_d     = piezo_q;
        take_grant  = 1'b0;
        found       = 1'b0;
        grant_key   = '0;
        idx         = 0;
        half        = HALF_TBL[cur_key_q*16 +: 16];

        // Search upward from the round-robin pointer, wrapping at N_KEYS.
        for (int i = 0; i < N_KEYS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_KEYS) begin
                idx = idx - N_KEYS;
            end
            if (!found && pending_q[idx]) begin
                found     = 1'b1;
                grant_key = idx[KW-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    take_grant = 1'b1;
                end
            end
            TONE: begin
                if (cnt_q == NOTE_LEN - 24'd1) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    piezo_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                    // A zero half-period is a rest: the pin simply never toggles.
                    if (half != 16'd0) begin
                        if (half_cnt_q == half - 16'd1) begin
                            piezo_d    = ~piezo_q;
                            half_cnt_d = '0;
                        end else begin
                            half_cnt_d = half_cnt_q + 16'd1;
                        end
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LEN - 24'd1) begin
                    cnt_d = '0;
                    if (found) begin
                        take_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_grant) begin
            state_d              = TONE;
            cnt_d                = '0;
            half_cnt_d           = '0;
            piezo_d              = 1'b0;
            cur_key_d            = grant_key;
            rr_d                 = (grant_key == KW'(N_KEYS - 1)) ? '0 : grant_key + KW'(1);
            pending_d[grant_key] = 1'b0;
        end

        // A trigger landing on its own grant cycle re-arms the request.
        pending_d = pending_d | key_trig;

        if (stop) begin
            state_d    = IDLE;
            pending_d  = '0;
            piezo_d    = 1'b0;
            cnt_d      = '0;
            half_cnt_d = '0;
        end

        busy_d      = (state_d != IDLE);
        cur_valid_d = (state_d == TONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            rr_q        <= '0;
            cur_key_q   <= '0;
            cnt_q       <= '0;
            half_cnt_q  <= '0;
            piezo_q     <= 1'b0;
            busy_q      <= 1'b0;
            cur_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_q        <= rr_d;
            cur_key_q   <= cur_key_d;
            cnt_q       <= cnt_d;
            half_cnt_q  <= half_cnt_d;
            piezo_q     <= piezo_d;
            busy_q      <= busy_d;
            cur_valid_q <= cur_valid_d;
        end
    end

    assign piezo     = piezo_q;
    assign busy      = busy_q;
    assign cur_key   = cur_key_q;
    assign cur_valid = cur_valid_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_piezo_key_arbiter.sv
// Self-checking bench for piezo_key_arbiter: a queue of expected grant keys is filled as triggers are driven
// and drained whenever the arbiter enters a new note; timing and tone shape are checked cycle by cycle.
module tb_piezo_key_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] keyTrig = 4'b0000;

    logic       piezo, busy, curValid;
    logic [1:0] curKey;
    logic [3:0] pending;

    logic       restPiezo, restBusy, restValid;
    logic [1:0] restKey;
    logic [3:0] restPending;

    int         checks = 0;
    int         errors = 0;
    int         expQ[$];
    logic       prevValid = 1'b0;

    piezo_key_arbiter #(
        .N_KEYS  (4),
        .NOTE_LEN(24'd20),
        .GAP_LEN (24'd4),
        .HALF_TBL({16'd5, 16'd4, 16'd3, 16'd2})
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_trig (keyTrig),
        .stop     (stop),
        .piezo    (piezo),
        .busy     (busy),
        .cur_key  (curKey),
        .cur_valid(curValid),
        .pending  (pending)
    );

    // Second copy with key 0 configured as a rest, driven by the same stimulus.
    piezo_key_arbiter #(
        .N_KEYS  (4),
        .NOTE_LEN(24'd20),
        .GAP_LEN (24'd4),
        .HALF_TBL({16'd5, 16'd4, 16'd3, 16'd0})
    ) dutRest (
        .clk      (clk),
        .rst      (rst),
        .key_trig (keyTrig),
        .stop     (stop),
        .piezo    (restPiezo),
        .busy     (restBusy),
        .cur_key  (restKey),
        .cur_valid(restValid),
        .pending  (restPending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample just after the edge; a new note pops the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (curValid && !prevValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedGrant", 32'(curKey), 32'hFFFF);
            end else begin
                checkOutput("grantKey", 32'(curKey), 32'(expQ.pop_front()));
            end
        end
        prevValid = curValid;
    endtask

    task automatic applyStimulus(input logic [3:0] trig, input logic stp);
        keyTrig = trig;
        stop    = stp;
        tick();
        keyTrig = 4'b0000;
        stop    = 1'b0;
    endtask

    task automatic resetDut();
        rst       = 1'b0;
        keyTrig   = 4'b0000;
        stop      = 1'b0;
        prevValid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || pending != 4'b0000) && n < 400) begin
            tick();
            n++;
        end
        checkOutput("idleTimeout", 32'(n >= 400), 32'd0);
    endtask

    initial begin
        $display("[TB] piezo_key_arbiter bench starting");

        // Reset values.
        tick();
        checkOutput("rst.piezo", 32'(piezo), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.curKey", 32'(curKey), 32'd0);
        checkOutput("rst.curValid", 32'(curValid), 32'd0);
        checkOutput("rst.pending", 32'(pending), 32'd0);
        rst = 1'b1;
        tick();

        // Single request on key 1 (half-period 3).
        resetDut();
        expQ.push_back(1);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("single.pendingT1", 32'(pending), 32'd2);
        checkOutput("single.busyT1", 32'(busy), 32'd0);
        for (int j = 0; j < 20; j++) begin
            tick();
            checkOutput($sformatf("single.piezo%0d", j), 32'(piezo), 32'((j / 3) % 2));
            checkOutput($sformatf("single.valid%0d", j), 32'(curValid), 32'd1);
            if (j == 0) begin
                checkOutput("single.busyT2", 32'(busy), 32'd1);
                checkOutput("single.curKeyT2", 32'(curKey), 32'd1);
                checkOutput("single.pendingT2", 32'(pending), 32'd0);
            end
        end
        tick();
        checkOutput("single.gapBusy", 32'(busy), 32'd1);
        checkOutput("single.gapValid", 32'(curValid), 32'd0);
        checkOutput("single.gapPiezo", 32'(piezo), 32'd0);
        checkOutput("single.gapKey", 32'(curKey), 32'd1);
        tick();
        tick();
        tick();
        checkOutput("single.gapEndBusy", 32'(busy), 32'd1);
        tick();
        checkOutput("single.idleBusy", 32'(busy), 32'd0);
        checkOutput("single.idleKey", 32'(curKey), 32'd1);

        // Simultaneous requests: back-to-back grants 0, 1, 3.
        resetDut();
        expQ.push_back(0);
        expQ.push_back(1);
        expQ.push_back(3);
        applyStimulus(4'b1011, 1'b0);
        begin
            int busyCycles = 0;
            tick();
            while (busy && busyCycles < 200) begin
                busyCycles++;
                tick();
            end
            checkOutput("simul.busyCycles", 32'(busyCycles), 32'd72);
        end
        // Pointer should be back at 0, so key 2 wins before key 3.
        expQ.push_back(2);
        expQ.push_back(3);
        applyStimulus(4'b1100, 1'b0);
        waitIdle();

        // Round-robin fairness: keys 0 and 2 arrive while key 3 plays.
        resetDut();
        expQ.push_back(3);
        applyStimulus(4'b1000, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick();
        end
        expQ.push_back(0);
        expQ.push_back(2);
        applyStimulus(4'b0101, 1'b0);
        checkOutput("rr.pending", 32'(pending), 32'd5);
        waitIdle();

        // Same-key retrigger on the grant cycle.
        resetDut();
        expQ.push_back(2);
        expQ.push_back(2);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("retrig.valid", 32'(curValid), 32'd1);
        checkOutput("retrig.pending", 32'(pending), 32'd4);
        waitIdle();

        // Stop mid-note with pending 0101; a trigger in the stop cycle is ignored.
        resetDut();
        expQ.push_back(0);
        applyStimulus(4'b0101, 1'b0);
        tick();
        applyStimulus(4'b0001, 1'b0);
        checkOutput("stop.pendingBefore", 32'(pending), 32'd5);
        for (int j = 0; j < 6; j++) begin
            tick();
        end
        checkOutput("stop.piezoBefore", 32'(piezo), 32'd1);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("stop.busy", 32'(busy), 32'd0);
        checkOutput("stop.valid", 32'(curValid), 32'd0);
        checkOutput("stop.piezo", 32'(piezo), 32'd0);
        checkOutput("stop.pending", 32'(pending), 32'd0);
        checkOutput("stop.curKey", 32'(curKey), 32'd0);
        tick();
        checkOutput("stop.pendingLater", 32'(pending), 32'd0);
        checkOutput("stop.busyLater", 32'(busy), 32'd0);
        // Pointer kept at 1 across stop: key 2 before key 0.
        expQ.push_back(2);
        expQ.push_back(0);
        applyStimulus(4'b0101, 1'b0);
        waitIdle();

        // Rest note on key 0 in the second instance.
        resetDut();
        expQ.push_back(0);
        applyStimulus(4'b0001, 1'b0);
        for (int j = 0; j < 20; j++) begin
            tick();
            checkOutput($sformatf("rest.piezo%0d", j), 32'(restPiezo), 32'd0);
            checkOutput($sformatf("rest.valid%0d", j), 32'(restValid), 32'd1);
            checkOutput($sformatf("tone0.piezo%0d", j), 32'(piezo), 32'((j / 2) % 2));
        end
        tick();
        checkOutput("rest.gapValid", 32'(restValid), 32'd0);
        checkOutput("rest.gapBusy", 32'(restBusy), 32'd1);
        waitIdle();

        // Asynchronous reset at TONE cycle 10 of key 1.
        expQ.push_back(1);
        applyStimulus(4'b0010, 1'b0);
        tick();
        applyStimulus(4'b1000, 1'b0);
        for (int j = 1; j < 10; j++) begin
            tick();
        end
        checkOutput("arst.keyBefore", 32'(curKey), 32'd1);
        checkOutput("arst.piezoBefore", 32'(piezo), 32'd1);
        checkOutput("arst.pendingBefore", 32'(pending), 32'd8);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("arst.piezo", 32'(piezo), 32'd0);
        checkOutput("arst.busy", 32'(busy), 32'd0);
        checkOutput("arst.curKey", 32'(curKey), 32'd0);
        checkOutput("arst.curValid", 32'(curValid), 32'd0);
        checkOutput("arst.pending", 32'(pending), 32'd0);
        resetDut();

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
